// File: rtl/probe_rr_arbiter_if.sv
// Handshake bundle between trace sources, the probe arbiter
// and the downstream capture logic.
`timescale 1ns/1ps

interface probe_rr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int SRC_W  = $clog2(N_REQ)
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [SRC_W-1:0]  out_src;
  logic              out_last;
  logic              out_cut;
  logic              out_ready;

  logic busy;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_src,
    input  out_last,
    input  out_cut,
    output out_ready,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready,
    output out_valid,
    output out_data,
    output out_src,
    output out_last,
    output out_cut,
    input  out_ready,
    output busy
  );

endinterface

// File: rtl/probe_rr_arbiter.sv
// Round-robin burst arbiter sharing the probe capture channel
// between trace sources, with a registered, source-tagged output.
`timescale 1ns/1ps

module probe_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8,
  localparam int SRC_W    = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  probe_rr_arbiter_if.slave    bus
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t state;

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] gnt_idx;
  logic [SRC_W-1:0] next_ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic [SRC_W-1:0] pick;
  logic [SRC_W:0]   cand;
  logic             found;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [SRC_W-1:0]  out_src;
  logic              out_last;
  logic              out_cut;
  logic              busy;

  logic [N_REQ-1:0]  ready;
  logic              can_load;
  logic              g_valid;
  logic              g_last;
  logic [DATA_W-1:0] g_data;
  logic              cap;
  logic              xfer;
  logic              seg_end;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (SRC_W+1)'(i);
      if (cand >= (SRC_W+1)'(N_REQ))
        cand = cand - (SRC_W+1)'(N_REQ);
      if (!found && bus.req_valid[cand[SRC_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[SRC_W-1:0];
      end
    end
  end

  assign can_load = !out_valid || bus.out_ready;
  assign g_valid  = bus.req_valid[gnt_idx];
  assign g_last   = bus.req_last[gnt_idx];
  assign g_data   = bus.req_data[gnt_idx*DATA_W +: DATA_W];

  assign cap     = beat_cnt == CNT_W'(MAX_BURST - 1);
  assign xfer    = (state == GRANT) && g_valid && can_load;
  assign seg_end = xfer && (g_last || cap);

  assign next_ptr = (gnt_idx == SRC_W'(N_REQ - 1))
                  ? '0
                  : gnt_idx + 1'b1;

  // Ready follows out_ready combinationally: no skid buffer.
  always_comb begin
    ready = '0;
    if (state == GRANT && can_load)
      ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            gnt_idx  <= pick;
            beat_cnt <= '0;
            busy     <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (xfer)
            beat_cnt <= beat_cnt + 1'b1;
          if (seg_end) begin
            rr_ptr <= next_ptr;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
      out_cut   <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_src   <= gnt_idx;
      out_last  <= g_last || cap;
      out_cut   <= cap && !g_last;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.req_ready = ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_src   = out_src;
  assign bus.out_last  = out_last;
  assign bus.out_cut   = out_cut;
  assign bus.busy      = busy;

endmodule
